// File: rtl/puf_soc_ro_cnt_array_if.sv
// Control/status and data bundle for the RO PUF window counter array.
// The master side drives the measurement controls and RO ticks; the slave side is the counter array.
interface puf_soc_ro_cnt_array_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int WIN_W  = 20
);
   logic                      i_start;
   logic                      i_abort;
   logic [WIN_W-1:0]          i_win_len;
   logic [NUM_CH-1:0]         i_ro_tick;
   logic                      o_busy;
   logic                      o_done;
   logic                      o_valid;
   logic [NUM_CH*CNT_W-1:0]   o_cnt;
   logic [NUM_CH-1:0]         o_sat;
   logic [NUM_CH/2-1:0]       o_resp;

   modport master (
      output i_start, i_abort, i_win_len, i_ro_tick,
      input  o_busy, o_done, o_valid, o_cnt, o_sat, o_resp
   );

   modport slave (
      input  i_start, i_abort, i_win_len, i_ro_tick,
      output o_busy, o_done, o_valid, o_cnt, o_sat, o_resp
   );
endinterface

// File: rtl/puf_soc_ro_cnt_array.sv
// Windowed, saturating multi-channel RO edge counter that produces pairwise PUF response bits.
// NUM_CH must be even and at least 2; channel 2k is compared against channel 2k+1.
module puf_soc_ro_cnt_array #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int WIN_W  = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   puf_soc_ro_cnt_array_if.slave  bus
);
   typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

   state_t                state_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  valid_q;
   logic [WIN_W-1:0]      win_len_q;
   logic [WIN_W-1:0]      win_cnt_q;
   logic [WIN_W-1:0]      win_cnt_d;
   logic [CNT_W-1:0]      cnt_q [NUM_CH];
   logic [CNT_W-1:0]      cnt_d [NUM_CH];
   logic [NUM_CH-1:0]     sat_q;
   logic [NUM_CH-1:0]     sat_set_d;
   logic [NUM_CH/2-1:0]   resp_q;
   logic [NUM_CH/2-1:0]   resp_d;
   logic                  win_end;
   logic                  start_ok;

   assign win_cnt_d = win_cnt_q + WIN_W'(1);
   assign win_end   = (win_cnt_d == win_len_q);
   assign start_ok  = bus.i_start && !bus.i_abort && (bus.i_win_len != '0);

   // Next counts are what the final-cycle response must see, so compare on cnt_d.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic cnt_full;
      assign cnt_full      = &cnt_q[gi];
      assign cnt_d[gi]     = (bus.i_ro_tick[gi] && !cnt_full) ? cnt_q[gi] + CNT_W'(1) : cnt_q[gi];
      assign sat_set_d[gi] = bus.i_ro_tick[gi] && cnt_full;
      assign bus.o_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
   end

   for (genvar gi = 0; gi < NUM_CH/2; gi++) begin : g_pair
      assign resp_d[gi] = (cnt_d[2*gi] > cnt_d[2*gi+1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         win_len_q <= '0;
         win_cnt_q <= '0;
         sat_q     <= '0;
         resp_q    <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  state_q   <= COUNT;
                  busy_q    <= 1'b1;
                  valid_q   <= 1'b0;
                  win_len_q <= bus.i_win_len;
                  win_cnt_q <= '0;
                  sat_q     <= '0;
                  resp_q    <= '0;
                  for (int c = 0; c < NUM_CH; c++) begin
                     cnt_q[c] <= '0;
                  end
               end else if (bus.i_abort) begin
                  valid_q <= 1'b0;
               end
            end
            COUNT: begin
               // Abort beats completion and drops this edge's ticks.
               if (bus.i_abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  win_cnt_q <= win_cnt_d;
                  sat_q     <= sat_q | sat_set_d;
                  for (int c = 0; c < NUM_CH; c++) begin
                     cnt_q[c] <= cnt_d[c];
                  end
                  if (win_end) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     valid_q <= 1'b1;
                     resp_q  <= resp_d;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy  = busy_q;
   assign bus.o_done  = done_q;
   assign bus.o_valid = valid_q;
   assign bus.o_sat   = sat_q;
   assign bus.o_resp  = resp_q;

endmodule

// File: tb/tb_puf_soc_ro_cnt_array.sv
// Directed bench for the RO counter array: a 4-channel/16-bit instance for timing,
// response, abort and reset cases, and a 2-channel/4-bit instance for saturation.
module tb_puf_soc_ro_cnt_array;
   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   puf_soc_ro_cnt_array_if #(.NUM_CH(4), .CNT_W(16), .WIN_W(20)) a_if ();
   puf_soc_ro_cnt_array_if #(.NUM_CH(2), .CNT_W(4),  .WIN_W(8))  b_if ();

   puf_soc_ro_cnt_array #(.NUM_CH(4), .CNT_W(16), .WIN_W(20)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if)
   );

   puf_soc_ro_cnt_array #(.NUM_CH(2), .CNT_W(4), .WIN_W(8)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      a_if.i_start = 1'b0; a_if.i_abort = 1'b0; a_if.i_win_len = '0; a_if.i_ro_tick = '0;
      b_if.i_start = 1'b0; b_if.i_abort = 1'b0; b_if.i_win_len = '0; b_if.i_ro_tick = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_busy",  a_if.o_busy,  0);
      chk("rst_done",  a_if.o_done,  0);
      chk("rst_valid", a_if.o_valid, 0);
      chk("rst_cnt",   a_if.o_cnt,   0);
      chk("rst_sat",   a_if.o_sat,   0);
      chk("rst_resp",  a_if.o_resp,  0);
      chk("rst_b_cnt", b_if.o_cnt,   0);
      rst_n = 1'b1;
      tick();

      // Basic run, W=10: ch0 always, ch1 odd edges, ch2 never, ch3 always
      a_if.i_win_len = 20'd10;
      a_if.i_start   = 1'b1;
      tick();
      a_if.i_start = 1'b0;
      chk("basic_busy_e0", a_if.o_busy, 1);
      chk("basic_cnt_e0",  a_if.o_cnt,  0);
      for (int e = 1; e <= 10; e++) begin
         a_if.i_ro_tick = {1'b1, 1'b0, (e % 2 == 1), 1'b1};
         tick();
         if (e < 10) chk("basic_early_done", a_if.o_done, 0);
         if (e == 4) chk("basic_live_cnt", a_if.o_cnt, {16'd4, 16'd0, 16'd2, 16'd4});
      end
      chk("basic_done",  a_if.o_done,  1);
      chk("basic_valid", a_if.o_valid, 1);
      chk("basic_busy",  a_if.o_busy,  0);
      chk("basic_cnt",   a_if.o_cnt,   {16'd10, 16'd0, 16'd5, 16'd10});
      chk("basic_resp",  a_if.o_resp,  2'b01);
      chk("basic_sat",   a_if.o_sat,   0);
      a_if.i_ro_tick = '0;
      tick();
      chk("basic_done_pulse", a_if.o_done,  0);
      chk("basic_valid_hold", a_if.o_valid, 1);

      // Start with zero window length is ignored
      a_if.i_win_len = '0;
      a_if.i_start   = 1'b1;
      tick();
      a_if.i_start = 1'b0;
      chk("zlen_busy",  a_if.o_busy,  0);
      chk("zlen_valid", a_if.o_valid, 1);
      chk("zlen_cnt",   a_if.o_cnt,   {16'd10, 16'd0, 16'd5, 16'd10});

      // W=6 with a re-start and a new length mid-window; both must be ignored
      a_if.i_win_len = 20'd6;
      a_if.i_start   = 1'b1;
      tick();
      a_if.i_start   = 1'b0;
      a_if.i_ro_tick = 4'b0001;
      for (int e = 1; e <= 6; e++) begin
         if (e == 3) begin
            a_if.i_start   = 1'b1;
            a_if.i_win_len = 20'd2;
         end else begin
            a_if.i_start = 1'b0;
         end
         tick();
         if (e == 5) begin
            chk("restart_done_e5", a_if.o_done, 0);
            chk("restart_busy_e5", a_if.o_busy, 1);
         end
      end
      a_if.i_start   = 1'b0;
      a_if.i_ro_tick = '0;
      chk("restart_done", a_if.o_done, 1);
      chk("restart_cnt",  a_if.o_cnt,  64'd6);
      chk("restart_resp", a_if.o_resp, 2'b01);

      // Abort in IDLE clears o_valid, leaves counts
      a_if.i_abort = 1'b1;
      tick();
      a_if.i_abort = 1'b0;
      chk("idle_abort_valid", a_if.o_valid, 0);
      chk("idle_abort_cnt",   a_if.o_cnt,   64'd6);

      // Abort at edge 40 of W=100 with ch0 ticking constantly
      a_if.i_win_len = 20'd100;
      a_if.i_start   = 1'b1;
      tick();
      a_if.i_start   = 1'b0;
      a_if.i_ro_tick = 4'b0001;
      repeat (39) tick();
      a_if.i_abort = 1'b1;
      tick();
      a_if.i_abort = 1'b0;
      chk("abort_cnt",   a_if.o_cnt,   64'd39);
      chk("abort_busy",  a_if.o_busy,  0);
      chk("abort_done",  a_if.o_done,  0);
      chk("abort_valid", a_if.o_valid, 0);
      tick();
      chk("abort_done_after", a_if.o_done, 0);
      chk("abort_cnt_frozen", a_if.o_cnt,  64'd39);

      // Abort on the completion edge of W=3
      a_if.i_win_len = 20'd3;
      a_if.i_start   = 1'b1;
      tick();
      a_if.i_start = 1'b0;
      repeat (2) tick();
      a_if.i_abort = 1'b1;
      tick();
      a_if.i_abort   = 1'b0;
      a_if.i_ro_tick = '0;
      chk("abrt_end_done",  a_if.o_done,  0);
      chk("abrt_end_valid", a_if.o_valid, 0);
      chk("abrt_end_busy",  a_if.o_busy,  0);
      chk("abrt_end_cnt",   a_if.o_cnt,   64'd2);

      // Asynchronous reset mid-window
      a_if.i_win_len = 20'd10;
      a_if.i_start   = 1'b1;
      tick();
      a_if.i_start   = 1'b0;
      a_if.i_ro_tick = 4'hF;
      repeat (4) tick();
      chk("pre_rst_cnt", a_if.o_cnt, {16'd4, 16'd4, 16'd4, 16'd4});
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",  a_if.o_busy,  0);
      chk("mid_rst_cnt",   a_if.o_cnt,   0);
      chk("mid_rst_valid", a_if.o_valid, 0);
      chk("mid_rst_done",  a_if.o_done,  0);
      #2;
      rst_n = 1'b1;

      // W=1 with all channels ticking (edge-0 ticks must not count)
      a_if.i_win_len = 20'd1;
      a_if.i_start   = 1'b1;
      tick();
      a_if.i_start = 1'b0;
      chk("w1_busy_e0", a_if.o_busy, 1);
      chk("w1_cnt_e0",  a_if.o_cnt,  0);
      tick();
      a_if.i_ro_tick = '0;
      chk("w1_cnt",   a_if.o_cnt,   {16'd1, 16'd1, 16'd1, 16'd1});
      chk("w1_resp",  a_if.o_resp,  2'b00);
      chk("w1_done",  a_if.o_done,  1);
      chk("w1_valid", a_if.o_valid, 1);
      chk("w1_busy",  a_if.o_busy,  0);

      // Saturation on the 4-bit instance, W=20
      b_if.i_win_len = 8'd20;
      b_if.i_start   = 1'b1;
      tick();
      b_if.i_start   = 1'b0;
      b_if.i_ro_tick = 2'b01;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e == 15) begin
            chk("sat_cnt_e15", b_if.o_cnt, 8'h0F);
            chk("sat_flag_e15", b_if.o_sat, 2'b00);
         end
         if (e == 16) begin
            chk("sat_cnt_e16", b_if.o_cnt, 8'h0F);
            chk("sat_flag_e16", b_if.o_sat, 2'b01);
         end
      end
      b_if.i_ro_tick = '0;
      chk("sat_done", b_if.o_done, 1);
      chk("sat_cnt",  b_if.o_cnt,  8'h0F);
      chk("sat_flag", b_if.o_sat,  2'b01);
      chk("sat_resp", b_if.o_resp, 1'b1);
      b_if.i_win_len = 8'd1;
      b_if.i_start   = 1'b1;
      tick();
      b_if.i_start = 1'b0;
      chk("sat_clear_flag", b_if.o_sat, 2'b00);
      chk("sat_clear_cnt",  b_if.o_cnt, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/puf_soc_ro_cnt_array.md
# puf_soc_ro_cnt_array

Multi-channel, parametrised window counter for the ring-oscillator PUF datapath in the PUF SoC. It counts synchronised RO edge ticks on `NUM_CH` channels over a programmable window of `clk` cycles. Per-channel counters saturate and report overflow. At window end it compares adjacent channel pairs to produce the raw PUF response bits, which the response/key logic reads downstream.

## Interface
- `NUM_CH`, default 4: number of RO channels; must be even and ≥ 2.
- `CNT_W`, default 16: width of each channel counter.
- `WIN_W`, default 20: width of the window-length register.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset. The reset is rst_n, asynchronous and active-low; the clock is clk.
- `i_start`, input, 1: start a measurement; sampled only in IDLE.
- `i_abort`, input, 1: abandon the current measurement.
- `i_win_len`, input, `WIN_W`: window length in `clk` cycles; latched on an accepted start.
- `i_ro_tick`, input, `NUM_CH`: per-channel edge pulse, already synchronised to `clk`; 1 means count one edge.
- `o_busy`, output, 1: high while in COUNT.
- `o_done`, output, 1: 1-cycle pulse marking window completion.
- `o_valid`, output, 1: counts and response are valid; holds until the next accepted start or abort.
- `o_cnt`, output, `NUM_CH*CNT_W`: flattened counters; channel c occupies bits [c*CNT_W +: CNT_W].
- `o_sat`, output, `NUM_CH`: sticky per-channel saturation flag.
- `o_resp`, output, `NUM_CH/2`: pairwise response bits.

## Operation
- FSM states: IDLE and COUNT. Reset state is IDLE.
- IDLE to COUNT:
  - Condition: `i_start`=1, `i_abort`=0 and `i_win_len`≠0.
  - Actions: latch `i_win_len`, clear all counters and `o_sat`, clear `o_valid` and `o_resp`, clear the window counter.
- If `i_win_len`=0 at start, the start is ignored: no state change and outputs unchanged.
- Behaviour in COUNT, every cycle:
  - The window counter increments by 1.
  - For each c with `i_ro_tick[c]`=1: if cnt[c] < 2^CNT_W−1, cnt[c] increments. Otherwise cnt[c] holds at all ones and `o_sat[c]` is set.
  - Counters never wrap.
  - `o_sat` stays set until the next accepted start.
- COUNT to IDLE (normal completion): on the cycle in which the window counter reaches the latched length, that cycle's ticks are still counted, and the block registers `o_done`=1, `o_valid`=1 and `o_resp`.
- Response rule: `o_resp[k]` = 1 iff cnt[2k] > cnt[2k+1], computed on the final counts including that last cycle's ticks. A tie gives 0.
- Abort: `i_abort`=1 in COUNT sends the FSM to IDLE on that edge. The ticks on that edge are not counted. There is no `o_done`, `o_valid` stays 0, and counters freeze at their current values.
- `i_abort` has priority over window completion on the same edge. In IDLE, `i_abort` clears `o_valid`.
- `i_start` during COUNT is ignored. `i_win_len` changes during COUNT have no effect.
- `o_cnt` shows the live running counts during COUNT. In IDLE it holds its last value.
- Reset values: `o_busy`=0, `o_done`=0, `o_valid`=0, `o_cnt`=0, `o_sat`=0, `o_resp`=0, window counter=0, latched length=0.
- An asserted `rst_n` mid-window immediately returns everything to these reset values.

## Timing
- Edge 0 samples the accepted `i_start`. `o_busy`=1 from edge 0 onward.
- With latched length W, ticks are sampled on edges 1..W (exactly W samples).
- After edge W: `o_done`=1 for one cycle, `o_valid`=1, `o_resp` valid, `o_busy`=0.
- Latency from start edge to done edge is W cycles. Back-to-back restart is possible: a start sampled on edge W+1 is accepted.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Basic run: NUM_CH=4, W=10. ch0 ticks every cycle, ch1 every other cycle, ch2 never, ch3 every cycle → cnt = {10, 5, 0, 10}, `o_resp`=2'b01, `o_done` pulses once after edge 10, `o_sat`=0.
- Saturation: CNT_W=4, W=20, ch0 ticks constantly → cnt0=15, `o_sat[0]`=1, no wrap. The next start clears `o_sat`.
- Abort: W=100, abort at edge 40 with ch0 ticking constantly → cnt0=39, no `o_done`, `o_valid`=0, `o_busy`=0 after edge 40.
- Ignored starts: `i_start` with `i_win_len`=0 in IDLE gives no state change. `i_start` re-pulsed mid-window leaves counts and timing unchanged (`o_done` still after edge W).
- Reset mid-window: drop `rst_n` at edge 5 of W=10 → all outputs 0 at once. After release, a new start runs cleanly.
- Boundary: W=1 with all channels ticking on edge 1 → cnt=1 on every channel, `o_resp`=0 (ties), `o_done` after edge 1. Abort and completion on the same edge → abort wins, no `o_done`.
